// File: rtl/lfsr_gen_pkg.sv
// Shared constants for the parametrised LFSR generator.
// MODE selects the feedback structure of every lfsr_step in the chain.
package lfsr_gen_pkg;

    localparam int unsigned LFSR_FIB = 0;
    localparam int unsigned LFSR_GAL = 1;

endpackage

// File: rtl/lfsr_step.sv
// One combinational LFSR step, right-shifting, in Fibonacci or Galois form.
// Both forms are built; MODE is a constant, so the unused one is pruned.
module lfsr_step
    import lfsr_gen_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'h1D),
    parameter logic [WIDTH-1:0] GMASK = WIDTH'(8'hB8),
    parameter int unsigned      MODE  = LFSR_FIB
) (
    input  logic [WIDTH-1:0] state_i,
    output logic [WIDTH-1:0] state_o
);

    logic             fb;
    logic [WIDTH-1:0] fib_next;
    logic [WIDTH-1:0] gal_next;

    always_comb begin
        fb       = ^(state_i & TAPS);
        fib_next = {fb, state_i[WIDTH-1:1]};
        gal_next = {1'b0, state_i[WIDTH-1:1]} ^ (state_i[0] ? GMASK : '0);
        state_o  = (MODE == LFSR_GAL) ? gal_next : fib_next;
    end

endmodule

// File: rtl/lfsr_gen.sv
// LFSR generator: STEPS unrolled steps per enabled clock, seed load with zero
// lockup recovery, and period measurement by matching sub-states against start.
module lfsr_gen
    import lfsr_gen_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'h1D),
    parameter logic [WIDTH-1:0] GMASK = WIDTH'(8'hB8),
    parameter int unsigned      MODE  = LFSR_FIB,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(8'hFF),
    parameter int unsigned      STEPS = 1,
    parameter int unsigned      CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             enable,
    output logic [WIDTH-1:0] out,
    output logic             sout,
    output logic             lockup,
    output logic             wrap,
    output logic [CNT_W-1:0] period,
    output logic             period_valid
);

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             period_valid_q, period_valid_d;
    logic             wrap_q, wrap_d;
    logic             lockup_q, lockup_d;

    logic [WIDTH-1:0] chain [STEPS+1];

    assign chain[0] = state_q;

    for (genvar g = 0; g < STEPS; g++) begin : g_step
        lfsr_step #(
            .WIDTH (WIDTH),
            .TAPS  (TAPS),
            .GMASK (GMASK),
            .MODE  (MODE)
        ) u_step (
            .state_i (chain[g]),
            .state_o (chain[g+1])
        );
    end

    logic             hit;
    logic [CNT_W:0]   hit_k;
    logic [CNT_W-1:0] restart_cnt;
    logic [CNT_W:0]   hit_sum;
    logic [CNT_W:0]   adv_sum;
    logic             period_ok;

    // Scan from the last sub-state down so the earliest match wins.
    always_comb begin
        hit         = 1'b0;
        hit_k       = '0;
        restart_cnt = '0;
        for (int unsigned k = STEPS; k >= 1; k--) begin
            if (chain[k] == start_q) begin
                hit         = 1'b1;
                hit_k       = (CNT_W+1)'(k);
                restart_cnt = CNT_W'(STEPS - k);
            end
        end
        hit_sum   = {1'b0, step_cnt_q} + hit_k;
        adv_sum   = {1'b0, step_cnt_q} + (CNT_W+1)'(STEPS);
        // A saturated or overflowing count means the true period is unknown.
        period_ok = !(&step_cnt_q) && !hit_sum[CNT_W];
    end

    always_comb begin
        state_d        = state_q;
        start_d        = start_q;
        step_cnt_d     = step_cnt_q;
        period_d       = period_q;
        period_valid_d = period_valid_q;
        wrap_d         = 1'b0;
        lockup_d       = 1'b0;
        if (clear) begin
            state_d        = SEED;
            start_d        = SEED;
            step_cnt_d     = '0;
            period_d       = '0;
            period_valid_d = 1'b0;
        end else if (load) begin
            state_d        = (load_val == '0) ? SEED : load_val;
            start_d        = (load_val == '0) ? SEED : load_val;
            lockup_d       = (load_val == '0);
            step_cnt_d     = '0;
            period_valid_d = 1'b0;
        end else if (enable) begin
            if (state_q == '0) begin
                state_d        = SEED;
                start_d        = SEED;
                lockup_d       = 1'b1;
                step_cnt_d     = '0;
                period_valid_d = 1'b0;
            end else begin
                state_d = chain[STEPS];
                if (hit) begin
                    wrap_d     = 1'b1;
                    step_cnt_d = restart_cnt;
                    if (period_ok) begin
                        period_d       = hit_sum[CNT_W-1:0];
                        period_valid_d = 1'b1;
                    end
                end else begin
                    step_cnt_d = adv_sum[CNT_W] ? '1 : adv_sum[CNT_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= SEED;
            start_q        <= SEED;
            step_cnt_q     <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            wrap_q         <= 1'b0;
            lockup_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            start_q        <= start_d;
            step_cnt_q     <= step_cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            wrap_q         <= wrap_d;
            lockup_q       <= lockup_d;
        end
    end

    assign out          = state_q;
    assign sout         = state_q[0];
    assign lockup       = lockup_q;
    assign wrap         = wrap_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;

endmodule
